lock_code_sender: RTL

Initiator-side companion to the combination lock. It takes a stored multi-digit switch code and drives a timed one-hot switch-press sequence onto the lock's 8-bit switch bus. It then watches the lock's locked/alarm outputs and reports success or failure. It is used as an automatic unlocker and as a self-test driver in the lab top level.

---
 rtl/lock_code_sender.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lock_code_sender.sv
// -----------------------------------------------------------------------------
// lock_code_sender
//
// Initiator-side companion to the combination lock. On an accepted start it
// snapshots a multi-digit switch code and plays it onto the lock's 8-bit
// switch bus as a timed sequence of one-hot presses. Each press is held for
// HOLD_CYCLES and followed by GAP_CYCLES of an all-zero bus. It then waits for
// the lock to report unlocked (success) or alarm (fail), or it times out
// (fail). An alarm seen while the code is still being sent aborts the attempt
// at once.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       single-cycle request to send the code (only honoured in IDLE)
//   code        3*NUM_DIGITS switch indices, digit 0 in [2:0] is sent first
//   locked_in   lock status from the lock, 1 = locked, 0 = unlocked
//   alarm_n_in  lock alarm, active-low (0 = wrong code entered)
//   switches    driven switch bus, one-hot while pressing, zero otherwise
//   busy        high while an attempt is in flight (not in the done cycle)
//   done        one-cycle pulse when the attempt finishes
//   success     result flag, valid from done, held until the next start
//   fail        result flag, valid from done, held until the next start
//
// All outputs come straight from flops. The next-state logic computes the
// next value of every output from the next state, so the outputs always line
// up with the state they describe.
// -----------------------------------------------------------------------------
module lock_code_sender #(
  parameter int NUM_DIGITS   = 4,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [3*NUM_DIGITS-1:0]   code,
  input  logic                      locked_in,
  input  logic                      alarm_n_in,
  output logic [7:0]                switches,
  output logic                      busy,
  output logic                      done,
  output logic                      success,
  output logic                      fail
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS     = 3'd1;
  localparam logic [2:0] ST_GAP       = 3'd2;
  localparam logic [2:0] ST_WAIT_RESP = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  // One shared phase counter. It is sized for the longest phase and is
  // cleared on every state entry.
  localparam int CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_HG > RESP_TIMEOUT) ? CNT_MAX_HG : RESP_TIMEOUT;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

  // Selects digit idx out of a packed code word.
  function automatic logic [2:0] digit_of(input logic [3*NUM_DIGITS-1:0] c,
                                          input logic [2:0] idx);
    logic [2:0] d;
    d = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = (idx == 3'(k)) ? c[3*k +: 3] : d;
    end
    return d;
  endfunction

  // Decodes a switch index into a one-hot bus value.
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  // State and datapath registers
  logic [2:0]              state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [2:0]              digit_r;
  logic [3*NUM_DIGITS-1:0] code_r;
  logic [7:0]              switches_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    success_r;
  logic                    fail_r;

  // Next-value signals
  logic [2:0]              state_s;
  logic [CNT_W-1:0]        cnt_s;
  logic [2:0]              digit_s;
  logic [3*NUM_DIGITS-1:0] code_s;
  logic [7:0]              switches_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    success_s;
  logic                    fail_s;

  // Next-state, counter, digit and result-flag logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    digit_s   = digit_r;
    code_s    = code_r;
    success_s = success_r;
    fail_s    = fail_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s   = ST_PRESS;
          cnt_s     = CNT_ZERO;
          digit_s   = 3'd0;
          code_s    = code;
          success_s = 1'b0;
          fail_s    = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_PRESS: begin
        // An alarm while sending aborts: the bus drops to zero next cycle.
        if (!alarm_n_in) begin
          state_s = ST_FINISH;
          cnt_s   = CNT_ZERO;
          fail_s  = 1'b1;
        end else if (cnt_r == HOLD_LAST) begin
          state_s = ST_GAP;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_GAP: begin
        if (!alarm_n_in) begin
          state_s = ST_FINISH;
          cnt_s   = CNT_ZERO;
          fail_s  = 1'b1;
        end else if (cnt_r == GAP_LAST) begin
          cnt_s = CNT_ZERO;
          if (digit_r == DIGIT_LAST) begin
            state_s = ST_WAIT_RESP;
          end else begin
            state_s = ST_PRESS;
            digit_s = digit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_WAIT_RESP: begin
        // The alarm is tested first so it wins over a simultaneous unlock.
        if (!alarm_n_in) begin
          state_s = ST_FINISH;
          cnt_s   = CNT_ZERO;
          fail_s  = 1'b1;
        end else if (!locked_in) begin
          state_s   = ST_FINISH;
          cnt_s     = CNT_ZERO;
          success_s = 1'b1;
        end else if (cnt_r == RESP_LAST) begin
          state_s = ST_FINISH;
          cnt_s   = CNT_ZERO;
          fail_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_FINISH: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
        digit_s = 3'd0;
      end
    endcase
  end

  // Output values derived from the upcoming state so the registered outputs
  // match the state they belong to
  always_comb begin
    if ((state_s == ST_PRESS) || (state_s == ST_GAP) || (state_s == ST_WAIT_RESP)) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end

    if (state_s == ST_FINISH) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end

    // code_s already holds the fresh code on the accepting edge, so the
    // first press appears in the cycle right after start.
    if (state_s == ST_PRESS) begin
      switches_s = onehot8(digit_of(code_s, digit_s));
    end else begin
      switches_s = 8'd0;
    end
  end

  // State, datapath and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      digit_r    <= 3'd0;
      code_r     <= '0;
      switches_r <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      success_r  <= 1'b0;
      fail_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      digit_r    <= digit_s;
      code_r     <= code_s;
      switches_r <= switches_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      success_r  <= success_s;
      fail_r     <= fail_s;
    end
  end

  assign switches = switches_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign success  = success_r;
  assign fail     = fail_r;

endmodule
